// File: rtl/trace_pkg.sv
// Shared types for the trace request path: memory op codes, staged trace
// entries and the request records held in the controller-facing queue.
package trace_pkg;

    localparam int ADDR_W  = 36;
    localparam int MEMOP_W = 2;
    localparam int TIME_W  = 32;
    localparam int TAG_W   = 8;

    typedef enum logic [MEMOP_W-1:0] {
        READ    = 2'd0,
        WRITE   = 2'd1,
        IFETCH  = 2'd2,
        ILLEGAL = 2'd3
    } memop_e;

    typedef struct packed {
        logic [TIME_W-1:0] timestamp;
        memop_e            op;
        logic [ADDR_W-1:0] addr;
    } trace_entry_t;

    typedef struct packed {
        memop_e            op;
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
    } req_t;

endpackage

// File: rtl/req_fifo.sv
// Circular request queue with registered occupancy. The head reads zero when
// empty so downstream fields are clean after reset.
module req_fifo
    import trace_pkg::*;
#(
    parameter int  DEPTH    = 16,
    parameter type req_type = req_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  req_type                  wdata,
    input  logic                     pop,
    output req_type                  rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    req_type         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // A push into a full queue is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != DEPTH_C) || do_pop);

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trace_request_queue.sv
// Holds one parsed trace entry until the CPU-cycle counter reaches its
// timestamp, then tags it and hands it to the memory-controller queue.
module trace_request_queue
    import trace_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_W,
    parameter int MEMOP_WIDTH = MEMOP_W,
    parameter int TIME_WIDTH  = TIME_W,
    parameter int TAG_WIDTH   = TAG_W,
    parameter int IN_BUFF_CT  = 16,
    parameter bit SKIP_IDLE   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tf_valid,
    output logic                          tf_ready,
    input  logic [TIME_WIDTH-1:0]         tf_time,
    input  logic [MEMOP_WIDTH-1:0]        tf_op,
    input  logic [ADDR_WIDTH-1:0]         tf_addr,
    output logic                          mc_valid,
    input  logic                          mc_ready,
    output logic [MEMOP_WIDTH-1:0]        mc_op,
    output logic [ADDR_WIDTH-1:0]         mc_addr,
    output logic [TAG_WIDTH-1:0]          mc_tag,
    output logic [TIME_WIDTH-1:0]         cur_time,
    output logic [$clog2(IN_BUFF_CT):0]   q_count,
    output logic                          q_full,
    output logic                          q_empty,
    output logic                          op_err,
    output logic                          order_err
);

    trace_entry_t           stage;
    logic                   stage_valid;
    logic [TIME_WIDTH-1:0]  last_time;
    logic [TIME_WIDTH-1:0]  time_inc;
    logic [TIME_WIDTH-1:0]  next_time;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   pop;
    logic                   rel;
    logic                   push;
    logic                   accept;
    logic                   stage_illegal;
    req_t                   q_wdata;
    req_t                   q_head;

    // Both ports transfer on a cycle where valid && ready; valid never waits
    // on ready, and the stage refills in the same cycle it releases.
    assign pop           = mc_valid && mc_ready;
    assign stage_illegal = (stage.op == ILLEGAL);
    assign rel           = stage_valid && (cur_time >= stage.timestamp) && (!q_full || pop);
    assign push          = rel && !stage_illegal;
    assign tf_ready      = !stage_valid || rel;
    assign accept        = tf_valid && tf_ready;
    assign time_inc      = cur_time + TIME_WIDTH'(1);

    always_comb begin
        next_time = time_inc;
        if (SKIP_IDLE && q_empty && stage_valid && (stage.timestamp > time_inc)) begin
            next_time = stage.timestamp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage       <= '0;
            cur_time    <= '0;
            last_time   <= '0;
            tag         <= '0;
            op_err      <= 1'b0;
            order_err   <= 1'b0;
        end else begin
            cur_time  <= next_time;
            op_err    <= rel && stage_illegal;
            order_err <= push && (stage.timestamp < last_time);
            if (push) begin
                last_time <= stage.timestamp;
                tag       <= tag + 1'b1;
            end
            if (accept) begin
                stage_valid <= 1'b1;
                stage       <= '{timestamp: tf_time, op: memop_e'(tf_op), addr: tf_addr};
            end else if (rel) begin
                stage_valid <= 1'b0;
            end
        end
    end

    assign q_wdata = '{op: stage.op, addr: stage.addr, tag: tag};

    req_fifo #(
        .DEPTH    (IN_BUFF_CT),
        .req_type (req_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (q_wdata),
        .pop   (pop),
        .rdata (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign mc_valid = !q_empty;
    assign mc_op    = q_head.op;
    assign mc_addr  = q_head.addr;
    assign mc_tag   = q_head.tag;

endmodule

// File: tb/tb_trace_request_queue.sv
// Directed bench for trace_request_queue: a vector table for op handling and
// tagging, plus sequences for skip-idle, full queue, ordering and reset.
module tb_trace_request_queue;

    localparam int AW = 36;
    localparam int OW = 2;
    localparam int TW = 32;
    localparam int GW = 8;
    localparam int RW = OW + AW + GW;

    logic          clk;
    logic          rst;
    logic          tf_valid;
    logic          tf_ready;
    logic [TW-1:0] tf_time;
    logic [OW-1:0] tf_op;
    logic [AW-1:0] tf_addr;
    logic          mc_valid;
    logic          mc_ready;
    logic [OW-1:0] mc_op;
    logic [AW-1:0] mc_addr;
    logic [GW-1:0] mc_tag;
    logic [TW-1:0] cur_time;
    logic [4:0]    q_count;
    logic          q_full;
    logic          q_empty;
    logic          op_err;
    logic          order_err;

    logic [RW-1:0] exp_q [$];
    int            chk_cnt;
    int            pass_cnt;

    typedef struct {
        logic [OW-1:0] op;
        logic [AW-1:0] addr;
        logic          exp_err;
        logic [4:0]    exp_count;
        logic [GW-1:0] exp_tag;
    } vec_t;

    vec_t vecs [8];

    trace_request_queue #(
        .ADDR_WIDTH  (AW),
        .MEMOP_WIDTH (OW),
        .TIME_WIDTH  (TW),
        .TAG_WIDTH   (GW),
        .IN_BUFF_CT  (16),
        .SKIP_IDLE   (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tf_valid  (tf_valid),
        .tf_ready  (tf_ready),
        .tf_time   (tf_time),
        .tf_op     (tf_op),
        .tf_addr   (tf_addr),
        .mc_valid  (mc_valid),
        .mc_ready  (mc_ready),
        .mc_op     (mc_op),
        .mc_addr   (mc_addr),
        .mc_tag    (mc_tag),
        .cur_time  (cur_time),
        .q_count   (q_count),
        .q_full    (q_full),
        .q_empty   (q_empty),
        .op_err    (op_err),
        .order_err (order_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tf_valid = 1'b0;
        mc_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // driver tasks
    task automatic push_entry(input logic [TW-1:0] t, input logic [OW-1:0] op, input logic [AW-1:0] addr);
        tf_time  = t;
        tf_op    = op;
        tf_addr  = addr;
        tf_valid = 1'b1;
        for (int i = 0; i < 50 && !tf_ready; i++) step();
        if (!tf_ready) chk("push_ready_timeout", 64'(tf_ready), 64'd1);
        step();
        tf_valid = 1'b0;
    endtask

    task automatic wait_mc_valid(input string name);
        for (int i = 0; i < 50 && !mc_valid; i++) step();
        chk(name, 64'(mc_valid), 64'd1);
    endtask

    task automatic drain(input int n);
        logic [RW-1:0] e;
        mc_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_mc_valid("drain_valid");
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("drain_head", 64'({mc_op, mc_addr, mc_tag}), 64'(e));
            end
            step();
        end
        mc_ready = 1'b0;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        rst      = 1'b1;
        tf_valid = 1'b0;
        tf_time  = '0;
        tf_op    = '0;
        tf_addr  = '0;
        mc_ready = 1'b0;

        vecs[0] = '{op: 2'd3, addr: 36'h0_0000_00A0, exp_err: 1'b1, exp_count: 5'd0, exp_tag: 8'd0};
        vecs[1] = '{op: 2'd1, addr: 36'h0_0000_0100, exp_err: 1'b0, exp_count: 5'd1, exp_tag: 8'd0};
        vecs[2] = '{op: 2'd0, addr: 36'hF_FFFF_FFFF, exp_err: 1'b0, exp_count: 5'd2, exp_tag: 8'd1};
        vecs[3] = '{op: 2'd2, addr: 36'h8_0000_0000, exp_err: 1'b0, exp_count: 5'd3, exp_tag: 8'd2};
        vecs[4] = '{op: 2'd3, addr: 36'h1_1111_1111, exp_err: 1'b1, exp_count: 5'd3, exp_tag: 8'd0};
        vecs[5] = '{op: 2'd3, addr: 36'h2_2222_2222, exp_err: 1'b1, exp_count: 5'd3, exp_tag: 8'd0};
        vecs[6] = '{op: 2'd0, addr: 36'h5_5555_5555, exp_err: 1'b0, exp_count: 5'd4, exp_tag: 8'd3};
        vecs[7] = '{op: 2'd1, addr: 36'hA_AAAA_AAAA, exp_err: 1'b0, exp_count: 5'd5, exp_tag: 8'd4};

        // reset state
        do_reset();
        chk("rst_q_count", 64'(q_count), 64'd0);
        chk("rst_mc_valid", 64'(mc_valid), 64'd0);
        chk("rst_q_empty", 64'(q_empty), 64'd1);
        chk("rst_q_full", 64'(q_full), 64'd0);
        chk("rst_tf_ready", 64'(tf_ready), 64'd1);
        chk("rst_cur_time", 64'(cur_time), 64'd0);
        chk("rst_head", 64'({mc_op, mc_addr, mc_tag}), 64'd0);
        chk("rst_errs", 64'({op_err, order_err}), 64'd0);

        // first entry: release when cur_time reaches 5
        push_entry(32'd5, 2'd0, 36'h1_2345_6789);
        wait_mc_valid("t1_valid");
        chk("t1_time_at_valid", 64'(cur_time), 64'd6);
        exp_q.push_back({2'd0, 36'h1_2345_6789, 8'd0});
        drain(1);
        chk("t1_empty_after", 64'(q_empty), 64'd1);

        // skip idle: counter jumps to the staged timestamp
        do_reset();
        step();
        step();
        step();
        chk("t2_time3", 64'(cur_time), 64'd3);
        push_entry(32'd1000, 2'd2, 36'h0_DEAD_BEEF);
        step();
        chk("t2_jump", 64'(cur_time), 64'd1000);
        chk("t2_not_yet", 64'(mc_valid), 64'd0);
        step();
        chk("t2_release", 64'(mc_valid), 64'd1);
        chk("t2_time_after", 64'(cur_time), 64'd1001);
        exp_q.push_back({2'd2, 36'h0_DEAD_BEEF, 8'd0});
        drain(1);

        // full queue with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            push_entry(32'd0, 2'd0, AW'(i));
            exp_q.push_back({2'd0, AW'(i), GW'(i - 1)});
        end
        chk("t3_full", 64'(q_full), 64'd1);
        chk("t3_count16", 64'(q_count), 64'd16);
        chk("t3_tf_ready_low", 64'(tf_ready), 64'd0);
        chk("t3_head", 64'({mc_op, mc_addr, mc_tag}), 64'(exp_q[0]));
        mc_ready = 1'b1;
        step();
        mc_ready = 1'b0;
        void'(exp_q.pop_front());
        chk("t3_count_hold", 64'(q_count), 64'd16);
        chk("t3_full_hold", 64'(q_full), 64'd1);
        chk("t3_tf_ready_back", 64'(tf_ready), 64'd1);
        drain(16);
        chk("t3_drained", 64'(q_empty), 64'd1);

        // table: op handling and tag allocation
        do_reset();
        for (int v = 0; v < 8; v++) begin
            push_entry(32'd0, vecs[v].op, vecs[v].addr);
            chk("tbl_op_err_idle", 64'(op_err), 64'd0);
            step();
            chk("tbl_op_err", 64'(op_err), 64'(vecs[v].exp_err));
            chk("tbl_q_count", 64'(q_count), 64'(vecs[v].exp_count));
            if (!vecs[v].exp_err) exp_q.push_back({vecs[v].op, vecs[v].addr, vecs[v].exp_tag});
        end
        drain(5);
        chk("tbl_drained", 64'(q_empty), 64'd1);

        // out-of-order timestamp still delivered
        do_reset();
        push_entry(32'd50, 2'd0, 36'h0_0000_0050);
        for (int i = 0; i < 100 && q_count != 5'd1; i++) step();
        chk("ord_first_in", 64'(q_count), 64'd1);
        chk("ord_no_err_first", 64'(order_err), 64'd0);
        push_entry(32'd20, 2'd1, 36'h0_0000_0020);
        chk("ord_no_err_stage", 64'(order_err), 64'd0);
        step();
        chk("ord_err_pulse", 64'(order_err), 64'd1);
        chk("ord_second_in", 64'(q_count), 64'd2);
        step();
        chk("ord_err_clear", 64'(order_err), 64'd0);
        exp_q.push_back({2'd0, 36'h0_0000_0050, 8'd0});
        exp_q.push_back({2'd1, 36'h0_0000_0020, 8'd1});
        drain(2);

        // reset mid-operation flushes everything
        do_reset();
        for (int i = 0; i < 6; i++) push_entry(32'd0, 2'd1, AW'(i + 8'h40));
        chk("mid_q_count5", 64'(q_count), 64'd5);
        chk("mid_staged", 64'(tf_ready), 64'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_count", 64'(q_count), 64'd0);
        chk("mid_rst_valid", 64'(mc_valid), 64'd0);
        chk("mid_rst_time", 64'(cur_time), 64'd0);
        chk("mid_rst_ready", 64'(tf_ready), 64'd1);
        rst = 1'b0;
        mc_ready = 1'b1;
        step();
        step();
        step();
        chk("mid_after_valid", 64'(mc_valid), 64'd0);
        chk("mid_after_count", 64'(q_count), 64'd0);
        mc_ready = 1'b0;

        // final report
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/trace_request_queue.md
# trace_request_queue

Synthesizable front end between the trace-file reader and the memory controller. It accepts parsed trace entries (time, op, address) over a valid/ready handshake and keeps a free-running CPU-cycle counter. It releases each entry into a parameterised request queue only once the counter reaches the entry's timestamp. The memory controller drains the queue through a second valid/ready port and receives a sequence tag with every request.

## Interface
- ADDR_WIDTH, 36: trace address width
- MEMOP_WIDTH, 2: op code width
- TIME_WIDTH, 32: timestamp and cycle-counter width
- TAG_WIDTH, 8: sequence tag width; wraps modulo 2^TAG_WIDTH
- IN_BUFF_CT, 16: queue depth; must be a power of two and at least 2
- SKIP_IDLE, 1: 1 = the counter jumps forward to the staged timestamp when the block is idle
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- tf_valid  in  1  trace entry present
- tf_ready  out  1  stage register can accept an entry
- tf_time  in  TIME_WIDTH  entry timestamp, in CPU cycles
- tf_op  in  MEMOP_WIDTH  0 read, 1 write, 2 ifetch, 3 illegal
- tf_addr  in  ADDR_WIDTH  target address
- mc_valid  out  1  queue head valid
- mc_ready  in  1  memory controller takes the head entry
- mc_op, mc_addr, mc_tag  out  MEMOP_WIDTH / ADDR_WIDTH / TAG_WIDTH  queue head fields
- cur_time  out  TIME_WIDTH  current CPU cycle
- q_count  out  $clog2(IN_BUFF_CT)+1  number of occupied entries
- q_full, q_empty  out  1  occupancy flags
- op_err  out  1  one-cycle pulse: illegal op dropped
- order_err  out  1  one-cycle pulse: timestamp lower than the previously released timestamp

## Operation
- Stage register: one entry plus a valid bit. tf_ready = !stage_valid || release.
- release = stage_valid && (cur_time >= stage_time) && (!q_full || pop).
  - pop = mc_valid && mc_ready.
- A staged illegal op (3) is discarded when its release condition is met. It pulses op_err, is not enqueued and does not advance the tag.
- Each enqueued entry takes the current tag value; the tag then increments.
- order_err pulses in the release cycle when stage_time is lower than the last released timestamp. The entry is still enqueued.
- Time counter:
  - increments by 1 every cycle.
  - if SKIP_IDLE=1, q_empty, stage_valid and stage_time > cur_time+1, it loads stage_time instead.
  - wraps at 2^TIME_WIDTH; wrap is not guarded.
- Queue: circular buffer with head/tail pointers of $clog2(IN_BUFF_CT) bits that wrap naturally.
  - Simultaneous push and pop leaves q_count unchanged and is legal when the queue is full.
  - A pop on an empty queue is ignored.
- Reset values: stage and queue empty, cur_time=0, tag=0, last-released time=0, tf_ready=1, mc_valid=0, q_empty=1, q_full=0, q_count=0, op_err=0, order_err=0. Head fields read 0.
- Reset asserted mid-operation flushes all staged and queued entries in that cycle. Nothing is delivered after reset.

## Timing
- Accept: the tf_valid&&tf_ready edge loads the stage register.
  - Earliest release is the following cycle, when stage_time <= cur_time.
  - Release does not happen in the accept cycle itself.
- Release to mc_valid: 1 cycle, because the queue is registered.
  - Minimum tf accept to mc_valid latency is 2 cycles.
- Throughput: 1 entry per cycle in steady state, because the stage register refills in its own release cycle.
- mc_* outputs are stable while mc_valid && !mc_ready.
- q_full, q_empty and q_count are registered and reflect the state after the last edge.
- op_err and order_err assert in the cycle after the release decision.

## Structure
- Package trace_pkg:
  - memop_e enum (READ=0, WRITE=1, IFETCH=2, ILLEGAL=3)
  - trace_entry_t struct {time, op, addr}
  - req_t struct {op, addr, tag}
- Sub-module req_fifo: parameterised by depth and req_t. It owns the pointers, count and flags.
- The top level owns the stage register, time counter, tag counter and error logic.

## Test plan
- Reset, then push {time=5, op=0, addr=0x1_2345_6789}:
  - mc_valid rises on the cycle after cur_time reaches 5.
  - Head fields are addr=0x123456789, tag=0.
- SKIP_IDLE=1, empty queue, push time=1000 at cur_time=3: cur_time loads 1000 within 2 cycles, and the entry is released at 1000.
- Hold mc_ready=0 and push 17 entries with time=0:
  - q_full=1 after 16 enqueues and tf_ready=0.
  - Raising mc_ready for one cycle enqueues entry 17 in that same cycle and leaves q_count=16.
- Push op=3, then op=1: op_err pulses once, and only the write reaches the controller, with tag=0.
- Push time=50, then time=20: order_err pulses on the second release, and both entries are delivered in order with tags 0 and 1.
- Assert rst with 5 entries queued and 1 staged: the next cycle shows q_count=0, mc_valid=0, cur_time=0 and tf_ready=1.
